// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: RV32I data-memory request/ack sequencer with load extension.
// Optional bus timeout fault is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_busReq,
  output logic        o_busWrite,
  output logic [31:0] o_busAddr,
  output logic [3:0]  o_busByteEn,
  output logic [31:0] o_busWdata,
  input  logic        i_busAck,
  input  logic [31:0] i_busRdata,
  output logic [31:0] o_rdata,
  output logic        o_rdValid,
  output logic        o_misaligned,
  output logic        o_busErr
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_waddr;
  logic [1:0]  r_off;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [31:0] r_rdata;

  logic        w_legal;
  logic        w_misal;
  logic        w_ok;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  // Size decode for the request presented in IDLE
  always_comb begin
    w_be    = 4'b1111;
    w_wd    = i_wdata;
    w_misal = 1'b0;
    unique case (1'b1)
      i_funct3[1:0] == 2'b00: begin
        w_be = 4'b0001 << i_addr[1:0];
        w_wd = {4{i_wdata[7:0]}};
      end
      i_funct3[1:0] == 2'b01: begin
        w_be    = 4'b0011 << i_addr[1:0];
        w_wd    = {2{i_wdata[15:0]}};
        w_misal = i_addr[0];
      end
      i_funct3[1:0] == 2'b10: w_misal = |i_addr[1:0];
      default: ;
    endcase
  end

  assign w_legal = (i_funct3[1:0] != 2'b11) &&
                   (!i_funct3[2] ||
                    (!i_memWrite && i_funct3[1:0] != 2'b10));
  assign w_ok    = w_legal && !w_misal;

  assign w_byte = 8'(i_busRdata >> {r_off, 3'b000});
  assign w_half = r_off[1] ? i_busRdata[31:16] : i_busRdata[15:0];

  always_comb begin
    w_ext = i_busRdata;
    unique case (1'b1)
      r_f3[1:0] == 2'b00:
        w_ext = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      r_f3[1:0] == 2'b01:
        w_ext = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_toErr;

  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_toErr <= 1'b0;
    end else begin
      if (r_state != S_REQ)
        r_cnt <= '0;
      else if (!i_busAck)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == S_IDLE)
        r_toErr <= 1'b0;
      else if (r_state == S_REQ && w_timeout && !i_busAck)
        r_toErr <= 1'b1;
    end
  end

  assign o_busErr     = (r_state == S_FAULT) && r_toErr;
  assign o_misaligned = (r_state == S_FAULT) && !r_toErr;
`else
  assign w_timeout    = 1'b0;
  assign o_busErr     = 1'b0;
  assign o_misaligned = (r_state == S_FAULT);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_memReq) w_next = w_ok ? S_REQ : S_FAULT;
      S_REQ:
        if (i_busAck)       w_next = S_DONE;
        else if (w_timeout) w_next = S_FAULT;
      S_DONE:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_off   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_f3    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_memReq && w_ok) begin
        r_waddr <= i_addr[31:2];
        r_off   <= i_addr[1:0];
        r_be    <= w_be;
        r_wdata <= w_wd;
        r_write <= i_memWrite;
        r_f3    <= i_funct3;
      end
      if (r_state == S_REQ && i_busAck && !r_write)
        r_rdata <= w_ext;
    end
  end

  // Stall is forced low during reset so the pipeline is released at once
  assign o_stall     = i_rst_n &&
                       ((r_state == S_IDLE && i_memReq) ||
                        r_state == S_REQ);
  assign o_busReq    = (r_state == S_REQ);
  assign o_busWrite  = (r_state == S_REQ) && r_write;
  assign o_busAddr   = {r_waddr, 2'b00};
  assign o_busByteEn = r_be;
  assign o_busWdata  = r_wdata;
  assign o_rdata     = r_rdata;
  assign o_rdValid   = (r_state == S_DONE) && !r_write;
endmodule
